// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared architectural constants for the integer register file
//               and its load scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Architectural register width.
  localparam int XLEN = 32;

  // Number of architectural registers, x0 included.
  localparam int NREG = 32;

  // Register address width, log2(NREG).
  localparam int AW = 5;

  // Address of the hardwired-zero register.
  localparam int REG_ZERO = 0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/reg_file_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb_if
// Description : Bundle between the pipeline (write-back and ID stages) and
//               the register file with load scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_sb_if #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int AW   = cpu_pkg::AW
);

  // Write-back port
  logic            WB_RegWrite;
  logic            WB_MemtoReg;
  logic [AW-1:0]   WB_rd_addr;
  logic [XLEN-1:0] WB_rd_data;

  // ID read ports
  logic [AW-1:0]   ID_rs1_addr;
  logic [AW-1:0]   ID_rs2_addr;
  logic [XLEN-1:0] ID_rs1_data;
  logic [XLEN-1:0] ID_rs2_data;
  logic            ID_use_rs1;
  logic            ID_use_rs2;

  // ID issue information for the scoreboard
  logic            ID_issue;
  logic            ID_is_load;
  logic [AW-1:0]   ID_rd_addr;
  logic            ID_stall;

  // Debug visibility of the number of in-flight load destinations
  logic [AW:0]     pending_cnt;

  // Pipeline side: drives write-back and decode information.
  modport master (
    output WB_RegWrite, WB_MemtoReg, WB_rd_addr, WB_rd_data,
    output ID_rs1_addr, ID_rs2_addr, ID_use_rs1, ID_use_rs2,
    output ID_issue, ID_is_load, ID_rd_addr,
    input  ID_rs1_data, ID_rs2_data, ID_stall, pending_cnt
  );

  // Register file side.
  modport slave (
    input  WB_RegWrite, WB_MemtoReg, WB_rd_addr, WB_rd_data,
    input  ID_rs1_addr, ID_rs2_addr, ID_use_rs1, ID_use_rs2,
    input  ID_issue, ID_is_load, ID_rd_addr,
    output ID_rs1_data, ID_rs2_data, ID_stall, pending_cnt
  );

endinterface : reg_file_sb_if
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register pending bits for loads in flight. Sets on load
//               issue, clears on load write-back (set wins on collision),
//               raises the ID stall and keeps a registered pending count.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = cpu_pkg::AW
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  // ID side
  input  wire logic          issue,
  input  wire logic          is_load,
  input  wire logic [AW-1:0] id_rd_addr,
  input  wire logic [AW-1:0] rs1_addr,
  input  wire logic [AW-1:0] rs2_addr,
  input  wire logic          use_rs1,
  input  wire logic          use_rs2,
  // Write-back side
  input  wire logic          wb_we,
  input  wire logic          wb_memtoreg,
  input  wire logic [AW-1:0] wb_rd_addr,
  // Results
  output logic               stall,
  output logic [AW:0]        pending_cnt
);

  import cpu_pkg::*;

  // One bit per architectural register; x0 can never be pending.
  logic [NREG-1:1] pending;
  logic [NREG-1:1] pending_nxt;
  logic [NREG-1:1] set_vec;
  logic [NREG-1:1] clr_vec;
  logic [NREG-1:1] sel1;
  logic [NREG-1:1] sel2;
  logic            set_en;
  logic            clr_en;
  logic            hit1;
  logic            hit2;
  logic [AW:0]     cnt_nxt;

  // A retiring load result; it releases its register in this very cycle.
  assign clr_en = wb_we & wb_memtoreg & (wb_rd_addr != AW'(REG_ZERO));

  // A new load may only claim its destination when ID actually advances.
  assign set_en = issue & is_load & (id_rd_addr != AW'(REG_ZERO)) & ~stall;

  // Decode the four addresses into one-hot vectors over x1..x(NREG-1).
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    sel1    = '0;
    sel2    = '0;
    for (int i = 1; i < NREG; i++) begin
      set_vec[i] = set_en & (id_rd_addr == AW'(i));
      clr_vec[i] = clr_en & (wb_rd_addr == AW'(i));
      sel1[i]    = (rs1_addr == AW'(i));
      sel2[i]    = (rs2_addr == AW'(i));
    end
  end

  // A register being cleared now is delivered by the bypass, so it is not a hit.
  assign hit1  = |(pending & sel1 & ~clr_vec);
  assign hit2  = |(pending & sel2 & ~clr_vec);
  assign stall = (use_rs1 & hit1) | (use_rs2 & hit2);

  // Next pending vector: clear first, then set, so a new load wins a collision.
  always_comb begin
    pending_nxt = (pending & ~clr_vec) | set_vec;
    cnt_nxt     = '0;
    for (int i = 1; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(pending_nxt[i]);
    end
  end

  // Pending vector and its population count move together on every edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Architectural register file (x0 hardwired to zero) with two
//               combinational read ports, same-cycle write-back bypass and a
//               load scoreboard that stalls ID on use of an in-flight load.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = cpu_pkg::AW
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  reg_file_sb_if.slave  bus
);

  import cpu_pkg::*;

  // x0 has no storage; entries 1..NREG-1 only.
  logic [XLEN-1:0] regs [NREG-1:1];
  logic            wr_en;

  // Writes to x0 are dropped here, so the array never holds an x0 value.
  assign wr_en = bus.WB_RegWrite & (bus.WB_rd_addr != AW'(REG_ZERO));

  // Architectural array: cleared by reset, written by write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[bus.WB_rd_addr] <= bus.WB_rd_data;
    end
  end

  // Read port 1: zero register, then write-back bypass, then array.
  always_comb begin
    bus.ID_rs1_data = '0;
    if (bus.ID_rs1_addr == AW'(REG_ZERO)) begin
      bus.ID_rs1_data = '0;
    end else if (bus.WB_RegWrite && (bus.WB_rd_addr == bus.ID_rs1_addr)) begin
      bus.ID_rs1_data = bus.WB_rd_data;
    end else begin
      bus.ID_rs1_data = regs[bus.ID_rs1_addr];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    bus.ID_rs2_data = '0;
    if (bus.ID_rs2_addr == AW'(REG_ZERO)) begin
      bus.ID_rs2_data = '0;
    end else if (bus.WB_RegWrite && (bus.WB_rd_addr == bus.ID_rs2_addr)) begin
      bus.ID_rs2_data = bus.WB_rd_data;
    end else begin
      bus.ID_rs2_data = regs[bus.ID_rs2_addr];
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue       (bus.ID_issue),
    .is_load     (bus.ID_is_load),
    .id_rd_addr  (bus.ID_rd_addr),
    .rs1_addr    (bus.ID_rs1_addr),
    .rs2_addr    (bus.ID_rs2_addr),
    .use_rs1     (bus.ID_use_rs1),
    .use_rs2     (bus.ID_use_rs2),
    .wb_we       (bus.WB_RegWrite),
    .wb_memtoreg (bus.WB_MemtoReg),
    .wb_rd_addr  (bus.WB_rd_addr),
    .stall       (bus.ID_stall),
    .pending_cnt (bus.pending_cnt)
  );

endmodule : reg_file_sb
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Directed plus random bench for reg_file_sb, compared against
//               an array/bit-set reference model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  reg_file_sb_if bus ();

  reg_file_sb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: register contents and the set of registers awaiting a load.
  logic [31:0] mregs [32];
  bit          lp    [32];

  // Compare one observed value with its expected value.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [4:0] wrd,
                       input logic [31:0] wdata,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic iss, input logic ld, input logic [4:0] idrd);
    bus.WB_RegWrite = we;
    bus.WB_MemtoReg = m2r;
    bus.WB_rd_addr  = wrd;
    bus.WB_rd_data  = wdata;
    bus.ID_rs1_addr = rs1;
    bus.ID_use_rs1  = u1;
    bus.ID_rs2_addr = rs2;
    bus.ID_use_rs2  = u2;
    bus.ID_issue    = iss;
    bus.ID_is_load  = ld;
    bus.ID_rd_addr  = idrd;
  endtask

  // What a read of register a returns right now.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.WB_RegWrite && bus.WB_rd_addr == a) return bus.WB_rd_data;
    return mregs[a];
  endfunction

  // True when the load result for register r is neither here nor arriving now.
  function automatic bit waiting(input logic [4:0] r);
    bit arriving;
    arriving = bus.WB_RegWrite && bus.WB_MemtoReg && (bus.WB_rd_addr == r);
    return (r != 5'd0) && lp[r] && !arriving;
  endfunction

  function automatic bit exp_stall();
    return (bus.ID_use_rs1 && waiting(bus.ID_rs1_addr)) ||
           (bus.ID_use_rs2 && waiting(bus.ID_rs2_addr));
  endfunction

  function automatic int model_cnt();
    int n = 0;
    for (int i = 1; i < 32; i++) n += int'(lp[i]);
    return n;
  endfunction

  // Let inputs settle and check every combinational output against the model.
  task automatic settle();
    #2;
    chk("rs1_data", 64'(bus.ID_rs1_data), 64'(exp_rd(bus.ID_rs1_addr)));
    chk("rs2_data", 64'(bus.ID_rs2_data), 64'(exp_rd(bus.ID_rs2_addr)));
    chk("stall",    64'(bus.ID_stall),    64'(exp_stall()));
  endtask

  // Clock edge: advance the model with the presented inputs, then check the count.
  task automatic tick();
    bit st;
    st = exp_stall();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mregs[i] = 32'd0;
        lp[i]    = 1'b0;
      end
    end else begin
      if (bus.WB_RegWrite && bus.WB_rd_addr != 5'd0) mregs[bus.WB_rd_addr] = bus.WB_rd_data;
      if (bus.WB_RegWrite && bus.WB_MemtoReg && bus.WB_rd_addr != 5'd0) lp[bus.WB_rd_addr] = 1'b0;
      if (bus.ID_issue && bus.ID_is_load && bus.ID_rd_addr != 5'd0 && !st) lp[bus.ID_rd_addr] = 1'b1;
    end
    #1;
    chk("pending_cnt", 64'(bus.pending_cnt), 64'(model_cnt()));
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 32'd0;
      lp[i]    = 1'b0;
    end

    // Reset state
    @(posedge clk);
    #1;
    chk("reset_cnt", 64'(bus.pending_cnt), 64'd0);
    cycle();
    rst_n = 1'b1;

    // All registers read zero after reset
    for (int r = 1; r < 32; r += 2) begin
      drive(0, 0, 0, 0, 5'(r), 1, 5'(r + 1 < 32 ? r + 1 : 1), 1, 0, 0, 0);
      settle();
      chk("rd_reset1", 64'(bus.ID_rs1_data), 64'd0);
      chk("rd_reset2", 64'(bus.ID_rs2_data), 64'd0);
      tick();
    end

    // Write to x0 is dropped
    drive(1, 0, 5'd0, 32'hDEADBEEF, 5'd0, 1, 5'd0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 5'd0, 1, 5'd0, 1, 0, 0, 0);
    settle();
    chk("x0_zero", 64'(bus.ID_rs1_data), 64'd0);
    tick();

    // Same-cycle bypass, then array read
    drive(1, 0, 5'd5, 32'h12345678, 5'd5, 1, 5'd0, 0, 0, 0, 0);
    settle();
    chk("bypass_x5", 64'(bus.ID_rs1_data), 64'h12345678);
    tick();
    drive(0, 0, 0, 0, 5'd5, 1, 5'd0, 0, 0, 0, 0);
    settle();
    chk("array_x5", 64'(bus.ID_rs1_data), 64'h12345678);
    tick();

    // Load-use stall on x7, released by its write-back in the same cycle
    drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd7);
    cycle();
    drive(0, 0, 0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 0);
    settle();
    chk("stall_x7", 64'(bus.ID_stall), 64'd1);
    chk("cnt_x7", 64'(bus.pending_cnt), 64'd1);
    tick();
    drive(1, 1, 5'd7, 32'h0000A5A5, 5'd0, 0, 5'd7, 1, 0, 0, 0);
    settle();
    chk("unstall_x7", 64'(bus.ID_stall), 64'd0);
    chk("data_x7", 64'(bus.ID_rs2_data), 64'h0000A5A5);
    tick();
    chk("cnt_x7_clr", 64'(bus.pending_cnt), 64'd0);

    // Retire and reissue on x9 in the same cycle: set wins
    drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd9);
    cycle();
    drive(1, 1, 5'd9, 32'h00000999, 5'd0, 0, 5'd0, 0, 1, 1, 5'd9);
    cycle();
    chk("cnt_x9", 64'(bus.pending_cnt), 64'd1);
    drive(0, 0, 0, 0, 5'd9, 1, 5'd0, 0, 0, 0, 0);
    settle();
    chk("stall_x9", 64'(bus.ID_stall), 64'd1);
    tick();
    drive(1, 1, 5'd9, 32'h00000998, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    cycle();

    // Unused source does not stall; ALU write-back does not clear
    drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd3);
    cycle();
    drive(0, 0, 0, 0, 5'd3, 0, 5'd0, 0, 0, 0, 0);
    settle();
    chk("nouse_x3", 64'(bus.ID_stall), 64'd0);
    tick();
    drive(1, 0, 5'd3, 32'h00000333, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    cycle();
    chk("alu_keep_x3", 64'(bus.pending_cnt), 64'd1);
    drive(0, 0, 0, 0, 5'd3, 1, 5'd0, 0, 0, 0, 0);
    settle();
    chk("stall_x3", 64'(bus.ID_stall), 64'd1);
    tick();

    // Several loads pending, then a reset flushes them
    drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd2);
    cycle();
    drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd4);
    cycle();
    drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd6);
    cycle();
    chk("cnt_four", 64'(bus.pending_cnt), 64'd4);
    drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("cnt_flush", 64'(bus.pending_cnt), 64'd0);
    drive(0, 0, 0, 0, 5'd2, 1, 5'd5, 1, 0, 0, 0);
    settle();
    chk("flush_stall", 64'(bus.ID_stall), 64'd0);
    chk("flush_rd1", 64'(bus.ID_rs1_data), 64'd0);
    chk("flush_rd2", 64'(bus.ID_rs2_data), 64'd0);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom(),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 4) < 3),
            5'($urandom_range(0, 31)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule : tb_reg_file_sb
`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Architectural register file with a load scoreboard. It receives the write-back port driven at the end of the pipeline, with WB_RegWrite, WB_rd_addr, WB_rd_data and WB_MemtoReg. It serves two combinational read ports to the ID stage, with same-cycle write bypass. It also tracks registers that are destinations of loads still in flight and raises a stall to ID when an instruction reads one of them.

## Interface
Parameters:
- XLEN, 32, register width
- NREG, 32, number of registers (x0 hardwired zero)
- AW, 5, register address width, equal to log2(NREG)

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  synchronous, active-low reset
- WB_RegWrite  in  1  write enable from write-back
- WB_MemtoReg  in  1  the write-back value is load data
- WB_rd_addr  in  AW  write address
- WB_rd_data  in  XLEN  write data
- ID_rs1_addr, ID_rs2_addr  in  AW  read addresses
- ID_rs1_data, ID_rs2_data  out  XLEN  read data (combinational)
- ID_use_rs1, ID_use_rs2  in  1  the decoded instruction actually reads rs1 / rs2
- ID_issue  in  1  the ID instruction advances to EX this cycle
- ID_is_load  in  1  the ID instruction is a load
- ID_rd_addr  in  AW  destination of the ID instruction
- ID_stall  out  1  hold ID/IF and inject a bubble into EX
- pending_cnt  out  AW+1  number of registers currently pending (debug/verification)

## Operation
- Storage: NREG-1 registers of XLEN bits. x0 is not stored.
- Write: at the posedge, if rst_n=1, WB_RegWrite=1 and WB_rd_addr≠0, then regs[WB_rd_addr] ← WB_rd_data. A write to x0 is silently dropped.
- Read, for each port independently:
  - addr=0 → 0.
  - Otherwise, if WB_RegWrite=1 and WB_rd_addr=addr → WB_rd_data (bypass).
  - Otherwise → regs[addr].
- Scoreboard: a pending[NREG-1:1] bit vector.
  - Set: ID_issue=1, ID_is_load=1, ID_rd_addr≠0 and ID_stall=0 → pending[ID_rd_addr] ← 1.
  - Clear: WB_RegWrite=1, WB_MemtoReg=1 and WB_rd_addr≠0 → pending[WB_rd_addr] ← 0.
  - Set and clear on the same address in the same cycle: set wins. An old load retires while a new load to the same register issues.
  - ID_issue is ignored while ID_stall=1; nothing is set.
- Stall: ID_stall = (ID_use_rs1 & hit1) | (ID_use_rs2 & hit2), where hitN = pending[rsN] & rsN≠0 & ~(clear this cycle on rsN). A register being cleared this cycle is served by the bypass, so it does not stall.
- pending_cnt equals popcount(pending), registered, and consistent with pending after every edge.

## Timing
- Reset (rst_n=0 at a posedge): all regs ← 0, pending ← 0, pending_cnt ← 0. Write and set are suppressed during that cycle.
- Combinational outputs while in reset: ID_rs*_data follow the cleared array and the bypass. ID_stall=0 once pending is cleared.
- Read latency is 0 cycles.
- Write-to-read: the same cycle via the bypass; from the array on the next cycle onward.
- Stall drops in the same cycle that the clearing write-back is presented.
- Reset asserted mid-operation discards all pending bits. In-flight loads are flushed by the pipeline reset.
- No multi-cycle states. The scoreboard is the only state machine: per-register IDLE → PENDING on set, PENDING → IDLE on clear.

## Structure
- Shared package (cpu_pkg): XLEN, NREG, AW and the constant REG_ZERO = 0.
- One natural sub-module: rf_scoreboard, holding the pending vector, the set/clear priority, the stall logic and pending_cnt. The array and bypass stay in reg_file_sb.

## Test plan
- Reset, then read x1..x31 → all 0. Write x0 ← 0xDEADBEEF, then read x0 → 0.
- WB writes x5 ← 0x12345678 while ID reads rs1=x5 in the same cycle → ID_rs1_data=0x12345678. Next cycle, with WB idle → still 0x12345678.
- Issue a load to x7, then next cycle ID reads rs2=x7 with ID_use_rs2=1 → ID_stall=1 and pending_cnt=1. Write-back of x7 with WB_MemtoReg=1 and data 0xA5A5 → stall 0 in the same cycle, rs2 data 0xA5A5, pending_cnt 0 after the edge.
- Load to x9 is pending. In the same cycle WB retires x9 and ID issues a new load to x9 → pending[x9] stays 1 and pending_cnt stays 1. An ID read of x9 in the next cycle → ID_stall=1.
- Load to x3 is pending. ID reads x3 with ID_use_rs1=0 → ID_stall=0. An ALU write-back to x3 (WB_MemtoReg=0) does not clear pending.
- Loads pending to x2, x4 and x6, then rst_n=0 for one cycle → pending_cnt=0, all reads 0, ID_stall=0.
